// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the uart_rx_gen2 receiver.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam int   MIN_PRESCALE = 4;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_gen2_if.sv
// Output handshake bundle of uart_rx_gen2: received word, error flags and valid/ready.
interface uart_rx_gen2_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  data_ready;
  logic                  par_err;
  logic                  stp_err;
  logic                  ovr_err;
  logic                  brk_det;

  modport master (
    output P_DATA, data_valid, par_err, stp_err, ovr_err, brk_det,
    input  data_ready
  );

  modport slave (
    input  P_DATA, data_valid, par_err, stp_err, ovr_err, brk_det,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, per-bit edge counter and 3-point majority sampler.
// bit_done_o pulses in the cycle after the third sample, with bit_o holding the vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int SCALER_WIDTH = 6,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_i,
  input  logic                    restart_i,
  input  logic [SCALER_WIDTH-1:0] prescale_i,
  output logic                    rx_sync_o,
  output logic                    fall_o,
  output logic                    bit_o,
  output logic                    bit_done_o
);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic [SYNC_STAGES-1:0]  sync_d;
  logic                    prev_q;
  logic [SCALER_WIDTH-1:0] cnt_q;
  logic [SCALER_WIDTH-1:0] half;
  logic                    cnt_last;
  logic [2:0]              smp_hit;
  logic [2:0]              smp_q;
  logic                    done_q;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = rx_i;
      end else begin : g_next
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
    // Sample points sit at h-1, h, h+1 around the bit centre.
    for (gi = 0; gi < 3; gi++) begin : g_hit
      assign smp_hit[gi] = (cnt_q == half + SCALER_WIDTH'(gi) - SCALER_WIDTH'(1));
    end
  endgenerate

  assign half       = prescale_i >> 1;
  assign cnt_last   = (cnt_q == prescale_i - SCALER_WIDTH'(1));
  assign rx_sync_o  = sync_q[SYNC_STAGES-1];
  assign fall_o     = prev_q & ~rx_sync_o;
  assign bit_o      = maj3(smp_q);
  assign bit_done_o = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
      smp_q  <= '1;
      done_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= rx_sync_o;
      if (restart_i) begin
        cnt_q  <= '0;
        done_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_last ? '0 : cnt_q + SCALER_WIDTH'(1);
        done_q <= smp_hit[2];
        for (int i = 0; i < 3; i++) begin
          if (smp_hit[i]) smp_q[i] <= rx_sync_o;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_gen2.sv
// UART receiver: frame FSM, shift register and valid/ready output stage with overrun.
// Define UART_RX_BREAK_DETECT_EN to turn all-zero frames into a brk_det pulse.
module uart_rx_gen2
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int SCALER_WIDTH = 6,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RX_IN,
  input  logic [SCALER_WIDTH-1:0] Prescale,
  input  logic                    PAR_EN,
  input  logic                    PAR_TYP,
  input  logic                    STOP2,
  uart_rx_gen2_if.master          rx_if
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [SCALER_WIDTH-1:0] MIN_P = SCALER_WIDTH'(MIN_PRESCALE);

  rx_state_e               state_q, state_d;
  logic [SCALER_WIDTH-1:0] presc_q;
  logic                    par_en_q, par_typ_q, stop2_q;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    stop_idx_q, stop_idx_d;
  logic                    par_bad_q, par_bad_d;
  logic                    stp_bad_q, stp_bad_d;
  logic                    par_exp;
  logic                    start_frame;
  logic                    frame_done;

  logic [DATA_WIDTH-1:0]   pdata_q;
  logic                    valid_q, par_err_q, stp_err_q, ovr_q;

  logic rx_s, fall, bit_val, bit_done;

`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_hit;
  logic brk_q;
`endif

  uart_rx_sampler #(
    .SCALER_WIDTH (SCALER_WIDTH),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_sampler (
    .clk        (CLK),
    .rst        (RST),
    .rx_i       (RX_IN),
    .restart_i  (start_frame),
    .prescale_i (presc_q),
    .rx_sync_o  (rx_s),
    .fall_o     (fall),
    .bit_o      (bit_val),
    .bit_done_o (bit_done)
  );

  always_comb begin
    par_exp = ^shift_q;
    case (par_typ_q)
      PAR_EVEN: par_exp = ^shift_q;
      PAR_ODD:  par_exp = ~(^shift_q);
      default:  par_exp = ^shift_q;
    endcase
  end

  // Each state consumes one bit per majority decision; the edge counter keeps
  // free-running across bit boundaries, so decisions stay one bit period apart.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    stop_idx_d  = stop_idx_q;
    par_bad_d   = par_bad_q;
    stp_bad_d   = stp_bad_q;
    start_frame = 1'b0;
    frame_done  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk_hit     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d     = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          if (bit_val) begin
            state_d = IDLE;
          end else begin
            state_d    = DATA;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            par_bad_d  = 1'b0;
            stp_bad_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_bad_d = bit_val ^ par_exp;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          stp_bad_d = stp_bad_q | ~bit_val;
`ifdef UART_RX_BREAK_DETECT_EN
          // Received parity bit is par_bad ^ expected; expected for all-zero data is PAR_TYP.
          if (!stop_idx_q && !bit_val && (shift_q == '0) &&
              !(par_en_q && (par_bad_q ^ par_typ_q))) begin
            brk_hit = 1'b1;
            state_d = BREAK;
          end else
`endif
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      par_bad_q  <= 1'b0;
      stp_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      par_bad_q  <= par_bad_d;
      stp_bad_q  <= stp_bad_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q   <= MIN_P;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (start_frame) begin
      presc_q   <= (Prescale < MIN_P) ? MIN_P : Prescale;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      stop2_q   <= STOP2;
    end
  end

  // A completing frame is taken if the slot is free or being emptied this cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pdata_q   <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (frame_done) begin
      if (!valid_q || rx_if.data_ready) begin
        pdata_q   <= shift_q;
        par_err_q <= par_bad_q;
        stp_err_q <= stp_bad_d;
        valid_q   <= 1'b1;
        if (valid_q) ovr_q <= 1'b0;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (valid_q && rx_if.data_ready) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) brk_q <= 1'b0;
    else     brk_q <= brk_hit;
  end
  assign rx_if.brk_det = brk_q;
`else
  assign rx_if.brk_det = 1'b0;
`endif

  assign rx_if.P_DATA     = pdata_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.par_err    = par_err_q;
  assign rx_if.stp_err    = stp_err_q;
  assign rx_if.ovr_err    = ovr_q;

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Directed + randomized bench for uart_rx_gen2 with a frame-level reference model.
// Honours UART_RX_BREAK_DETECT_EN for the break scenario.
module tb_uart_rx_gen2;

  logic       CLK      = 1'b0;
  logic       RST      = 1'b1;
  logic       RX_IN    = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN   = 1'b0;
  logic       PAR_TYP  = 1'b0;
  logic       STOP2    = 1'b0;

  uart_rx_gen2_if #(.DATA_WIDTH(8)) bus();

  uart_rx_gen2 #(
    .DATA_WIDTH   (8),
    .SCALER_WIDTH (6),
    .SYNC_STAGES  (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_IN    (RX_IN),
    .Prescale (Prescale),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .STOP2    (STOP2),
    .rx_if    (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } frm_t;

  frm_t exp_q[$];
  frm_t got_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   vcyc    = 0;
  int   brk_cnt = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.data_valid) vcyc++;
      if (bus.brk_det) brk_cnt++;
      if (bus.data_valid && bus.data_ready)
        got_q.push_back('{d: bus.P_DATA, pe: bus.par_err, se: bus.stp_err});
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Parity rule stated on the whole frame: total ones (data + parity) even for PAR_TYP=0, odd for 1.
  function automatic frm_t model(input logic [7:0] d, input bit pe, input bit pt, input bit pb,
                                 input bit s2, input bit b1, input bit b2);
    frm_t f;
    int ones;
    ones = $countones(d) + int'(pb);
    f.d  = d;
    f.pe = pe && ((ones % 2) != int'(pt));
    f.se = !b1 || (s2 && !b2);
    return f;
  endfunction

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int pcfg, input bit pe, input bit pt, input bit pb,
                      input bit s2, input bit b1, input bit b2, input bit scr, output frm_t f);
    int bt;
    Prescale = 6'(pcfg);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    STOP2    = s2;
    bt = (pcfg < 4) ? 4 : pcfg;
    drive_bit(1'b0, bt);
    if (scr) begin
      Prescale = 6'($urandom_range(4, 63));
      PAR_EN   = ~pe;
      PAR_TYP  = ~pt;
      STOP2    = ~s2;
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
    if (pe) drive_bit(pb, bt);
    drive_bit(b1, bt);
    if (s2) drive_bit(b2, bt);
    drive_bit(1'b1, 3 * bt);
    f = model(d, pe, pt, pb, s2, b1, b2);
  endtask

  task automatic drain(input string tag);
    frm_t g, e;
    chk($sformatf("%s.count", tag), got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s.data", tag), int'(g.d), int'(e.d));
      chk($sformatf("%s.par_err", tag), int'(g.pe), int'(e.pe));
      chk($sformatf("%s.stp_err", tag), int'(g.se), int'(e.se));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    frm_t f, fx;
    int v0, b0, p;
    logic [7:0] d;
    bit pe, pt, pb, s2, b1, b2;

    bus.data_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.valid", int'(bus.data_valid), 0);
    chk("rst.pdata", int'(bus.P_DATA), 0);
    chk("rst.flags", int'({bus.par_err, bus.stp_err, bus.ovr_err, bus.brk_det}), 0);
    RST = 1'b0;
    drive_bit(1'b1, 5);

    v0 = vcyc;
    send(8'hA5, 8, 0, 0, 0, 0, 1, 1, 0, f);
    exp_q.push_back(f);
    drain("t1");
    chk("t1.valid_cycles", vcyc - v0, 1);

    send(8'h07, 16, 1, 0, 0, 0, 1, 1, 0, f);
    exp_q.push_back(f);
    drain("t2");

    send(8'h3C, 32, 0, 0, 0, 1, 1, 0, 0, f);
    exp_q.push_back(f);
    drain("t3");

    bus.data_ready = 1'b0;
    send(8'h11, 8, 0, 0, 0, 0, 1, 1, 0, f);
    send(8'h22, 8, 0, 0, 0, 0, 1, 1, 0, fx);
    chk("t4.held_valid", int'(bus.data_valid), 1);
    chk("t4.held_pdata", int'(bus.P_DATA), int'(f.d));
    chk("t4.ovr_set", int'(bus.ovr_err), 1);
    bus.data_ready = 1'b1;
    exp_q.push_back(f);
    drive_bit(1'b1, 1);
    chk("t4.valid_after_hs", int'(bus.data_valid), 0);
    chk("t4.ovr_after_hs", int'(bus.ovr_err), 0);
    drain("t4");

    Prescale = 6'd16;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 48);
    drain("t5.glitch");
    send(8'h5A, 16, 0, 0, 0, 0, 1, 1, 0, f);
    exp_q.push_back(f);
    drain("t5.after");

    b0 = brk_cnt;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    STOP2    = 1'b0;
    drive_bit(1'b0, 12 * 8);
    drive_bit(1'b1, 40);
`ifdef UART_RX_BREAK_DETECT_EN
    chk("t6.brk_pulses", brk_cnt - b0, 1);
`else
    chk("t6.brk_pulses", brk_cnt - b0, 0);
    exp_q.push_back(model(8'h00, 0, 0, 0, 0, 0, 0));
`endif
    drain("t6");

    send(8'hC3, 2, 1, 1, 1, 0, 1, 1, 0, f);
    exp_q.push_back(f);
    drain("pmin");

    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom);
      p  = $urandom_range(4, 24);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      b1 = ($urandom_range(0, 3) != 0);
      b2 = ($urandom_range(0, 3) != 0);
      if (d == 8'h00) b1 = 1'b1;
      send(d, p, pe, pt, pb, s2, b1, b2, (p >= 8), f);
      exp_q.push_back(f);
      drain($sformatf("rnd%0d", n));
    end

    bus.data_ready = 1'b0;
    send(8'h96, 8, 0, 0, 0, 0, 1, 1, 0, f);
    chk("rstmid.held", int'(bus.P_DATA), 32'h96);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 20);
    RST = 1'b1;
    drive_bit(1'b1, 2);
    chk("rstmid.valid", int'(bus.data_valid), 0);
    chk("rstmid.pdata", int'(bus.P_DATA), 0);
    RST = 1'b0;
    bus.data_ready = 1'b1;
    drive_bit(1'b1, 150);
    chk("rstmid.no_frame", int'(bus.data_valid), 0);
    drain("rstmid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
